// File: rtl/mem_stage_dcache.sv
// MEM-stage data cache: direct-mapped, one 32-bit word per line,
// write-through with no write-allocate, backed by a slow main memory
// through a req/ack handshake. Drives the pipeline-wide advance signal
// (hit) and resolves branches (PCSrc).
`timescale 1ns/1ps
module mem_stage_dcache #(
    parameter int INDEX_BITS = 4,
    localparam int TAG_BITS = 30 - INDEX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        Branch,
    input  logic        zeroFlag,
    input  logic [31:0] ALUResult,
    input  logic [31:0] readDataTwo,
    output logic [31:0] readData,
    output logic        hit,
    output logic        PCSrc,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] missCount
);

    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                state_r;
    state_t                nextState_s;

    logic [LINES-1:0]      valid_r;
    logic [TAG_BITS-1:0]   tagArr_r  [LINES];
    logic [31:0]           dataArr_r [LINES];

    logic [31:0]           readData_r;
    logic [15:0]           missCount_r;
    logic                  memReq_r;
    logic                  memWe_r;
    logic [29:0]           memAddr_r;
    logic [31:0]           memWdata_r;

    logic [29:0]           wordAddr_s;
    logic [INDEX_BITS-1:0] index_s;
    logic [TAG_BITS-1:0]   tag_s;
    logic                  lookupHit_s;
    logic                  startRead_s;
    logic                  startWrite_s;
    logic                  ackSeen_s;
    logic                  unusedAddrBits_s;

    // Byte offset within the word plays no part in the lookup.
    assign unusedAddrBits_s = ^ALUResult[1:0];

    // Branch resolution is independent of the cache state.
    assign PCSrc = Branch & zeroFlag;

    // In IDLE the live EX/MEM address is looked up; while waiting the
    // captured request address is used so fill/update targets the right line.
    always_comb begin
        if (state_r == IDLE) begin
            wordAddr_s = ALUResult[31:2];
        end else begin
            wordAddr_s = memAddr_r;
        end
    end

    assign index_s     = wordAddr_s[INDEX_BITS-1:0];
    assign tag_s       = wordAddr_s[29:INDEX_BITS];
    assign lookupHit_s = valid_r[index_s] & (tagArr_r[index_s] == tag_s);

    // A simultaneous read and write request is handled as a write.
    assign startWrite_s = (state_r == IDLE) & MemWrite;
    assign startRead_s  = (state_r == IDLE) & MemRead & ~MemWrite & ~lookupHit_s;
    assign ackSeen_s    = ((state_r == RD_WAIT) | (state_r == WR_WAIT)) & mem_ack;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state logic; acks outside the wait states are ignored.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (MemWrite) begin
                    nextState_s = WR_WAIT;
                end else if (MemRead && !lookupHit_s) begin
                    nextState_s = RD_WAIT;
                end else begin
                    nextState_s = IDLE;
                end
            end
            RD_WAIT: begin
                if (mem_ack) begin
                    nextState_s = DONE;
                end else begin
                    nextState_s = RD_WAIT;
                end
            end
            WR_WAIT: begin
                if (mem_ack) begin
                    nextState_s = DONE;
                end else begin
                    nextState_s = WR_WAIT;
                end
            end
            DONE:    nextState_s = IDLE;
            default: nextState_s = IDLE;
        endcase
    end

    // Advance signal and load data: zero-latency on an IDLE read hit,
    // captured fill data otherwise.
    always_comb begin
        hit      = 1'b1;
        readData = readData_r;
        if (rst) begin
            hit      = 1'b1;
            readData = readData_r;
        end else begin
            case (state_r)
                IDLE: begin
                    if (MemWrite) begin
                        hit = 1'b0;
                    end else if (MemRead && !lookupHit_s) begin
                        hit = 1'b0;
                    end else if (MemRead) begin
                        hit      = 1'b1;
                        readData = dataArr_r[index_s];
                    end else begin
                        hit = 1'b1;
                    end
                end
                RD_WAIT: hit = 1'b0;
                WR_WAIT: hit = 1'b0;
                DONE:    hit = 1'b1;
                default: hit = 1'b1;
            endcase
        end
    end

    // Backing-memory request registers: captured at request start and held
    // stable until the ack, so the memory sees a constant transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            memReq_r   <= 1'b0;
            memWe_r    <= 1'b0;
            memAddr_r  <= 30'd0;
            memWdata_r <= 32'd0;
        end else if (startWrite_s || startRead_s) begin
            memReq_r   <= 1'b1;
            memWe_r    <= startWrite_s;
            memAddr_r  <= ALUResult[31:2];
            memWdata_r <= readDataTwo;
        end else if (ackSeen_s) begin
            memReq_r   <= 1'b0;
            memWe_r    <= 1'b0;
        end
    end

    assign mem_req   = memReq_r;
    assign mem_we    = memWe_r;
    assign mem_addr  = memAddr_r;
    assign mem_wdata = memWdata_r;

    // Valid bits: cleared by reset, set when a read fill completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
        end else if ((state_r == RD_WAIT) && mem_ack) begin
            valid_r[index_s] <= 1'b1;
        end
    end

    // Tag/data storage: fill on read ack, update in place on a store hit
    // (stores to absent lines do not allocate).
    always_ff @(posedge clk) begin
        if (!rst && (state_r == RD_WAIT) && mem_ack) begin
            tagArr_r[index_s]  <= tag_s;
            dataArr_r[index_s] <= mem_rdata;
        end else if (!rst && (state_r == WR_WAIT) && mem_ack && lookupHit_s) begin
            dataArr_r[index_s] <= memWdata_r;
        end
    end

    // Captured load data presented in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            readData_r <= 32'd0;
        end else if ((state_r == RD_WAIT) && mem_ack) begin
            readData_r <= mem_rdata;
        end
    end

    // Saturating read-miss counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            missCount_r <= 16'd0;
        end else if (startRead_s && (missCount_r != 16'hFFFF)) begin
            missCount_r <= missCount_r + 16'd1;
        end
    end

    assign missCount = missCount_r;

endmodule

// File: tb/tb_mem_stage_dcache.sv
// Self-checking bench for mem_stage_dcache: directed vector table,
// hand-written corner sequences and randomized traffic against a
// line-array / main-memory reference model.
`timescale 1ns/1ps
module tb_mem_stage_dcache;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite, Branch, zeroFlag;
    logic [31:0] ALUResult, readDataTwo;
    logic [31:0] readData;
    logic        hit, PCSrc, mem_req, mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack;
    logic [15:0] missCount;

    mem_stage_dcache #(.INDEX_BITS(4)) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .Branch(Branch), .zeroFlag(zeroFlag), .ALUResult(ALUResult),
        .readDataTwo(readDataTwo), .readData(readData), .hit(hit),
        .PCSrc(PCSrc), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .missCount(missCount)
    );

    always #5 clk = ~clk;

    int passCount  = 0;
    int checkCount = 0;

    // Reference model: 16 lines, word-addressed main memory, counters.
    bit          refValid [16];
    logic [25:0] refTag   [16];
    logic [31:0] refData  [16];
    logic [31:0] refReadReg;
    int          refMiss;
    logic [31:0] mainMem [int unsigned];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] memRead(input logic [29:0] wa);
        int unsigned key;
        key = {2'b00, wa};
        if (mainMem.exists(key)) return mainMem[key];
        return (key * 32'h9E3779B1) + 32'h5BD1E995;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 16; i++) refValid[i] = 1'b0;
        refReadReg = 32'd0;
        refMiss    = 0;
    endtask

    task automatic randomBranch();
        Branch   = 1'($urandom_range(0, 1));
        zeroFlag = 1'($urandom_range(0, 1));
    endtask

    // One pipeline access. Starts and ends 1ns after a rising edge.
    task automatic runOp(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int lat,
                         output bit firstHit, output logic [31:0] outData,
                         output logic [15:0] outMiss);
        int          idx;
        bit          isHit;
        logic [31:0] fill;
        idx   = int'(addr[5:2]);
        isHit = refValid[idx] && (refTag[idx] == addr[31:6]);
        MemRead = rd; MemWrite = wr; ALUResult = addr; readDataTwo = wdata;
        mem_ack = (!rd && !wr) ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata = $urandom;
        randomBranch();
        @(negedge clk);
        firstHit = hit; outData = readData; outMiss = missCount;
        check1("pcsrc_idle", PCSrc, Branch & zeroFlag);
        check1("req_idle", mem_req, 1'b0);
        if (!rd && !wr) begin
            check1("nop_hit", hit, 1'b1);
            @(posedge clk); #1; mem_ack = 1'b0;
            return;
        end
        if (rd && !wr && isHit) begin
            check1("rdhit_hit", hit, 1'b1);
            check32("rdhit_data", readData, refData[idx]);
            check32("rdhit_miss", {16'd0, missCount}, 32'(refMiss));
            @(posedge clk); #1;
            return;
        end
        check1("stall_first", hit, 1'b0);
        if (!wr && refMiss < 65535) refMiss++;
        fill = memRead(addr[31:2]);
        @(posedge clk); #1;
        for (int c = 0; c <= lat; c++) begin
            randomBranch();
            mem_ack   = (c == lat);
            mem_rdata = (c == lat && !wr) ? fill : $urandom;
            @(negedge clk);
            check1("wait_hit", hit, 1'b0);
            check1("wait_req", mem_req, 1'b1);
            check1("wait_we", mem_we, wr);
            check32("wait_addr", {2'b00, mem_addr}, {2'b00, addr[31:2]});
            if (wr) check32("wait_wdata", mem_wdata, wdata);
            check1("pcsrc_wait", PCSrc, Branch & zeroFlag);
            @(posedge clk); #1;
        end
        // DONE: a stray ack here must be ignored.
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        if (!wr) begin
            refValid[idx] = 1'b1; refTag[idx] = addr[31:6];
            refData[idx]  = fill; refReadReg  = fill;
        end else begin
            mainMem[{2'b00, addr[31:2]}] = wdata;
            if (isHit) refData[idx] = wdata;
        end
        @(negedge clk);
        check1("done_hit", hit, 1'b1);
        check32("done_data", readData, refReadReg);
        check32("done_miss", {16'd0, missCount}, 32'(refMiss));
        outData = readData; outMiss = missCount;
        @(posedge clk); #1;
        mem_ack = 1'b0;
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        bit          expHit;
        logic [31:0] expData;
        logic [15:0] expMiss;
    } vec_t;

    vec_t vecs[10];

    initial begin
        bit          fh;
        logic [31:0] od;
        logic [15:0] om;

        vecs[0] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,          2, 1'b0, 32'hDEADBEEF, 16'd1};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,          0, 1'b1, 32'hDEADBEEF, 16'd1};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0440, 32'h0,          1, 1'b0, 32'hCAFEF00D, 16'd2};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,          0, 1'b0, 32'hDEADBEEF, 16'd3};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_0040, 32'h12345678,   3, 1'b0, 32'hDEADBEEF, 16'd3};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,          0, 1'b1, 32'h12345678, 16'd3};
        vecs[6] = '{1'b0, 1'b1, 32'h0000_0080, 32'hA5A5A5A5,   1, 1'b0, 32'hDEADBEEF, 16'd3};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,          1, 1'b0, 32'hA5A5A5A5, 16'd4};
        vecs[8] = '{1'b1, 1'b1, 32'h0000_0080, 32'h11112222,   0, 1'b0, 32'hA5A5A5A5, 16'd4};
        vecs[9] = '{1'b1, 1'b0, 32'h0000_0083, 32'h0,          0, 1'b1, 32'h11112222, 16'd4};

        mainMem[32'h10]  = 32'hDEADBEEF;
        mainMem[32'h110] = 32'hCAFEF00D;

        rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Branch = 1'b0; zeroFlag = 1'b0;
        ALUResult = 32'd0; readDataTwo = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
        modelReset();
        @(negedge clk);
        check1("hit_during_reset", hit, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check1("rst_hit", hit, 1'b1);
        check32("rst_readData", readData, 32'd0);
        check32("rst_missCount", {16'd0, missCount}, 32'd0);
        check1("rst_req", mem_req, 1'b0);
        check1("rst_we", mem_we, 1'b0);
        @(posedge clk); #1;

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            runOp(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].lat, fh, od, om);
            check1($sformatf("vec%0d_firstHit", i), fh, vecs[i].expHit);
            check32($sformatf("vec%0d_data", i), od, vecs[i].expData);
            check32($sformatf("vec%0d_miss", i), {16'd0, om}, {16'd0, vecs[i].expMiss});
        end

        // Branch resolution in IDLE.
        MemRead = 1'b0; MemWrite = 1'b0; Branch = 1'b1; zeroFlag = 1'b1;
        #1 check1("pcsrc_taken", PCSrc, 1'b1);
        zeroFlag = 1'b0;
        #1 check1("pcsrc_not_taken", PCSrc, 1'b0);
        @(posedge clk); #1;

        // Saturation: preset the counter just below the ceiling.
        force dut.missCount_r = 16'hFFFE;
        @(negedge clk);
        release dut.missCount_r;
        refMiss = 65534;
        @(posedge clk); #1;
        runOp(1'b1, 1'b0, 32'h0000_1000, 32'h0, 0, fh, od, om);
        check32("sat_first", {16'd0, om}, 32'h0000_FFFF);
        runOp(1'b1, 1'b0, 32'h0000_2000, 32'h0, 1, fh, od, om);
        check32("sat_hold", {16'd0, om}, 32'h0000_FFFF);

        // Reset in the middle of a read miss.
        MemRead = 1'b1; MemWrite = 1'b0; ALUResult = 32'h0000_0840;
        @(negedge clk);
        check1("rstmid_stall", hit, 1'b0);
        @(posedge clk); #1;
        Branch = 1'b1; zeroFlag = 1'b1;
        @(negedge clk);
        check1("rstmid_req", mem_req, 1'b1);
        check1("rstmid_pcsrc", PCSrc, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check1("rstmid_hit_forced", hit, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0; MemRead = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        modelReset();
        @(negedge clk);
        check1("rstmid_req_low", mem_req, 1'b0);
        check32("rstmid_readData", readData, 32'd0);
        check32("rstmid_miss", {16'd0, missCount}, 32'd0);
        check1("rstmid_hit", hit, 1'b1);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check1("rstmid_stray_ignored", mem_req, 1'b0);
        @(posedge clk); #1;
        runOp(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, fh, od, om);
        check1("rstmid_line_invalid", fh, 1'b0);
        check32("rstmid_refill", od, 32'h12345678);

        // Randomized traffic over a small tag pool to mix hits and conflicts.
        for (int n = 0; n < 300; n++) begin
            int          kind;
            logic [25:0] tg;
            logic [31:0] a;
            kind = $urandom_range(0, 19);
            tg   = 26'($urandom_range(0, 3));
            if (tg == 26'd3) tg = 26'h3FF_FFFF;
            a = {tg, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if (kind < 12)      runOp(1'b1, 1'b0, a, $urandom, $urandom_range(0, 4), fh, od, om);
            else if (kind < 17) runOp(1'b0, 1'b1, a, $urandom, $urandom_range(0, 4), fh, od, om);
            else if (kind < 18) runOp(1'b1, 1'b1, a, $urandom, $urandom_range(0, 4), fh, od, om);
            else                runOp(1'b0, 1'b0, a, $urandom, 0, fh, od, om);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_stage_dcache.md
Name: mem_stage_dcache

Overview:
- MEM-stage data cache, directly downstream of the EX/MEM pipeline register; consumes its MemRead/MemWrite/ALUResult/readDataTwo/Branch/zeroFlag outputs.
- Direct-mapped, one 32-bit word per line, write-through, no write-allocate, backed by a slow main memory through a req/ack handshake.
- Drives the pipeline-wide `hit` (advance) signal that every pipeline register uses as its enable. Also resolves branches.

Parameters:
- INDEX_BITS, 4, log2 of line count (default 16 lines).
- TAG_BITS, 30-INDEX_BITS, derived; not overridable.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- MemRead  input  1  load request from EX/MEM.
- MemWrite  input  1  store request from EX/MEM.
- Branch  input  1  branch instruction flag.
- zeroFlag  input  1  ALU zero flag.
- ALUResult  input  32  byte address.
- readDataTwo  input  32  store data.
- readData  output  32  load data to MEM/WB.
- hit  output  1  1 = stage complete, pipeline may advance.
- PCSrc  output  1  Branch & zeroFlag, combinational.
- mem_req  output  1  backing-memory request.
- mem_we  output  1  1 = write transaction.
- mem_addr  output  30  word address (ALUResult[31:2]).
- mem_wdata  output  32  store data.
- mem_rdata  input  32  read data, valid with mem_ack.
- mem_ack  input  1  one-cycle completion pulse.
- missCount  output  16  saturating read-miss counter.

Behaviour:
- Address split:
  - ALUResult[1:0] ignored.
  - index = ALUResult[INDEX_BITS+1:2].
  - tag = ALUResult[31:INDEX_BITS+2].
  - lookup_hit = valid[index] & tag match.
- Reset (sync, rst=1 at posedge):
  - all valid bits cleared; state=IDLE; readData register=0; missCount=0; mem_req=0, mem_we=0.
  - hit forced 1 while rst high.
  - Reset mid-transaction aborts it. mem_req is low from the next cycle; a late mem_ack is ignored.
- States: IDLE, RD_WAIT, WR_WAIT, DONE.
- IDLE:
  - No MemRead/MemWrite: hit=1.
  - MemRead & lookup_hit: hit=1; readData=line data combinationally; zero-latency.
  - MemRead & miss: hit=0; next RD_WAIT; missCount+1, saturating at 16'hFFFF.
  - MemWrite (any tag): hit=0; next WR_WAIT.
  - MemRead & MemWrite both set: treated as a write.
- RD_WAIT:
  - mem_req=1, mem_we=0, hit=0.
  - On mem_ack: line[index] <= {valid=1, tag, mem_rdata}; readData register <= mem_rdata; next DONE.
- WR_WAIT:
  - mem_req=1, mem_we=1, mem_wdata=readDataTwo, hit=0.
  - On mem_ack: if lookup_hit, line data <= readDataTwo; otherwise the cache is unchanged (no allocate). Next DONE.
- DONE:
  - hit=1 for exactly one cycle; readData driven from the captured register.
  - The upstream negedge-clocked register latches the next instruction. Next state is IDLE unconditionally.
- Outputs are held stable while waiting: mem_addr and mem_wdata are constant from request until ack. Inputs from EX/MEM are frozen by hit=0.
- mem_ack arriving in IDLE or DONE is ignored.
- Back-to-back accesses to the same index: a read after a miss fill hits in IDLE. A store to a hit line then a load returns the new data.
- PCSrc is purely combinational and independent of the FSM state.

Test Plan:
- Reset, then read 0x0000_0040; memory acks 3 cycles later with 0xDEADBEEF -> hit=0 for 4 cycles, then DONE with readData=0xDEADBEEF, missCount=1. Re-reading 0x40 -> hit=1 in the same cycle, readData=0xDEADBEEF, missCount stays 1.
- Conflict miss with INDEX_BITS=4: fill 0x40, then read 0x440 (same index, different tag) -> miss, refill. Read 0x40 again -> miss, missCount=3.
- Write 0x12345678 to cached 0x40 -> mem_req=1, mem_we=1, mem_addr=0x10 until ack. A later read of 0x40 hits with 0x12345678. Write to uncached 0x80 -> memory written; read of 0x80 still misses.
- Assert rst during RD_WAIT -> next cycle mem_req=0, state IDLE, readData=0. A stray mem_ack is ignored. The line at 0x40 is invalid (next read misses).
- Branch=1, zeroFlag=1 -> PCSrc=1 in the same cycle. With zeroFlag=0 -> PCSrc=0. This holds regardless of a pending miss.
- Force missCount to 16'hFFFF via 65535 misses (or a backdoor preset), then one more miss -> remains 16'hFFFF.
